cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 159 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: sequences fetch, decode, data-processing,
// load/store and branch instructions, counts retired instructions and
// halts with a sticky error on an undefined class or a memory timeout.
module cpu_control_fsm #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR,
    input  logic        cond_ok,
    input  logic        mem_ready,
    output logic        write_pc,
    output logic        write_ir,
    output logic        pc_branch,
    output logic        write_reg,
    output logic        wb_sel,
    output logic        write_nzcv,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt,
    output logic        err
);

    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC_DP = 4'd3;
    localparam logic [3:0] S_WB_DP   = 4'd4;
    localparam logic [3:0] S_ADDR_LS = 4'd5;
    localparam logic [3:0] S_MEM     = 4'd6;
    localparam logic [3:0] S_WB_LD   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_HALT    = 4'd15;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    logic [3:0] next_state;
    logic       retire;
    logic [7:0] wait_cnt;
    logic       l_bit;
    // Goes high on the first posedge after reset release; until then the
    // machine sits in FETCH with every enable held off.
    logic       run;

    // Only the class, link and S/L fields of IR steer this block.
    logic unused_ir;
    assign unused_ir = ^{IR[31:28], IR[25], IR[23:21], IR[19:0]};

    // State register with the run qualifier that delays the first FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) state <= next_state;
        end
    end

    // Next-state decode; also flags retirement into FETCH.
    always_comb begin
        next_state = S_HALT;
        retire     = 1'b0;
        case (state)
            S_FETCH:   next_state = cond_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (IR[27:26])
                    2'b00:   next_state = S_EXEC_DP;
                    2'b01:   next_state = S_ADDR_LS;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_HALT;
                endcase
            end
            S_EXEC_DP: next_state = S_WB_DP;
            S_WB_DP: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_ADDR_LS: next_state = S_MEM;
            S_MEM: begin
                // Completion wins over timeout when both land on one cycle.
                if (mem_ready) begin
                    next_state = l_bit ? S_WB_LD : S_FETCH;
                    retire     = ~l_bit;
                end else if (wait_cnt == LIMIT) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_MEM;
                end
            end
            S_WB_LD: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default:   next_state = S_HALT;
        endcase
    end

    // Bookkeeping: retire counter, sticky error, memory wait counter, L latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= 32'd0;
            err       <= 1'b0;
            wait_cnt  <= 8'd0;
            l_bit     <= 1'b0;
        end else if (run) begin
            if (retire) instr_cnt <= instr_cnt + 32'd1;
            if (next_state == S_HALT) err <= 1'b1;
            if (state == S_ADDR_LS) begin
                wait_cnt <= 8'd0;
                l_bit    <= IR[20];
            end else if (state == S_MEM && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Moore output decode, all enables off until the machine is running.
    always_comb begin
        write_pc   = 1'b0;
        write_ir   = 1'b0;
        pc_branch  = 1'b0;
        write_reg  = 1'b0;
        wb_sel     = 1'b0;
        write_nzcv = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    write_pc = 1'b1;
                    write_ir = 1'b1;
                end
                S_WB_DP: begin
                    write_reg  = 1'b1;
                    write_nzcv = IR[20];
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = ~l_bit;
                end
                S_WB_LD: begin
                    write_reg = 1'b1;
                    wb_sel    = 1'b1;
                end
                S_BRANCH: begin
                    pc_branch = 1'b1;
                    write_reg = IR[24];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: random instruction streams checked cycle by
// cycle against an instruction-level model of the expected state trace.
module tb_cpu_control_fsm;

    localparam int WAIT_LIMIT = 15;

    // Bit masks into the packed control vector
    localparam logic [8:0] C_PC   = 9'b1_0000_0000;
    localparam logic [8:0] C_IR   = 9'b0_1000_0000;
    localparam logic [8:0] C_PCB  = 9'b0_0100_0000;
    localparam logic [8:0] C_WREG = 9'b0_0010_0000;
    localparam logic [8:0] C_WBS  = 9'b0_0001_0000;
    localparam logic [8:0] C_NZCV = 9'b0_0000_1000;
    localparam logic [8:0] C_MREQ = 9'b0_0000_0100;
    localparam logic [8:0] C_MWE  = 9'b0_0000_0010;
    localparam logic [8:0] C_ERR  = 9'b0_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] IR;
    logic        cond_ok;
    logic        mem_ready;
    logic        write_pc, write_ir, pc_branch, write_reg, wb_sel;
    logic        write_nzcv, mem_req, mem_we, err;
    logic [3:0]  state;
    logic [31:0] instr_cnt;
    logic [8:0]  ctrl_vec;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 32'd0;

    cpu_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .IR         (IR),
        .cond_ok    (cond_ok),
        .mem_ready  (mem_ready),
        .write_pc   (write_pc),
        .write_ir   (write_ir),
        .pc_branch  (pc_branch),
        .write_reg  (write_reg),
        .wb_sel     (wb_sel),
        .write_nzcv (write_nzcv),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .state      (state),
        .instr_cnt  (instr_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {write_pc, write_ir, pc_branch, write_reg, wb_sel,
                       write_nzcv, mem_req, mem_we, err};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Called just after a posedge with inputs already set; checks the
    // current cycle on the falling edge and advances to the next cycle.
    task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [8:0] ctl);
        @(negedge clk);
        check_val({tag, " state"}, 32'(state), 32'(st));
        check_val({tag, " ctrl"}, 32'(ctrl_vec), 32'(ctl));
        check_val({tag, " instr_cnt"}, instr_cnt, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    // Drop reset mid-cycle, confirm the asynchronous clear, then release so
    // the next full cycle is an active FETCH.
    task automatic reset_mid_cycle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 32'd0;
        check_val("async state", 32'(state), 32'd1);
        check_val("async ctrl", 32'(ctrl_vec), 32'd0);
        check_val("async instr_cnt", instr_cnt, 32'd0);
        @(negedge clk);
        check_val("rst held ctrl", 32'(ctrl_vec), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic halt_and_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            cond_ok   = 1'($urandom);
            mem_ready = 1'($urandom);
            IR        = $urandom;
            expect_cycle({tag, " halt"}, 4'd15, C_ERR);
        end
        mem_ready = 1'b0;
        reset_mid_cycle();
    endtask

    // One instruction: class, IR[20] (S or L), IR[24] link, condition
    // result, and number of not-ready MEM cycles before completion
    // (at or above WAIT_LIMIT+1 means memory never answers).
    task automatic run_instr(input logic [1:0] cls, input logic b20, input logic b24,
                             input logic cok, input int lat);
        logic [31:0] r;
        logic        done;
        r         = $urandom;
        r[27:26]  = cls;
        r[24]     = b24;
        r[20]     = b20;
        IR        = r;
        cond_ok   = cok;
        mem_ready = 1'b0;
        expect_cycle("fetch", 4'd1, C_PC | C_IR);
        if (!cok) return;
        cond_ok = 1'($urandom);
        expect_cycle("decode", 4'd2, 9'd0);
        case (cls)
            2'b00: begin
                expect_cycle("exec_dp", 4'd3, 9'd0);
                expect_cycle("wb_dp", 4'd4, C_WREG | (b20 ? C_NZCV : 9'd0));
                exp_cnt++;
            end
            2'b10: begin
                expect_cycle("branch", 4'd8, C_PCB | (b24 ? C_WREG : 9'd0));
                exp_cnt++;
            end
            2'b01: begin
                expect_cycle("addr_ls", 4'd5, 9'd0);
                done = 1'b0;
                for (int i = 0; i <= WAIT_LIMIT && !done; i++) begin
                    // L must come from the latch, not from a changing IR
                    IR        = $urandom;
                    mem_ready = (i == lat);
                    done      = mem_ready;
                    expect_cycle("mem", 4'd6, C_MREQ | (b20 ? 9'd0 : C_MWE));
                end
                mem_ready = 1'b0;
                if (!done) begin
                    halt_and_reset("timeout");
                end else if (b20) begin
                    expect_cycle("wb_ld", 4'd7, C_WREG | C_WBS);
                    exp_cnt++;
                end else begin
                    exp_cnt++;
                end
            end
            default: halt_and_reset("undef");
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        IR        = 32'd0;
        cond_ok   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset state", 32'(state), 32'd1);
        check_val("reset ctrl", 32'(ctrl_vec), 32'd0);
        check_val("reset instr_cnt", instr_cnt, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios
        run_instr(2'b00, 1'b1, 1'b0, 1'b1, 0);       // DP with S=1
        for (int k = 0; k < 3; k++)
            run_instr(2'b00, 1'b0, 1'b0, 1'b0, 0);   // condition fails
        run_instr(2'b01, 1'b1, 1'b0, 1'b1, 3);       // load, ready after 3
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 3);       // store, ready after 3
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 15);      // ready on the last cycle
        run_instr(2'b10, 1'b0, 1'b1, 1'b1, 0);       // branch with link
        run_instr(2'b01, 1'b0, 1'b0, 1'b1, 1000);    // store timeout
        run_instr(2'b00, 1'b0, 1'b0, 1'b1, 0);
        run_instr(2'b11, 1'b0, 1'b0, 1'b1, 0);       // undefined class

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            int          sel;
            logic [1:0]  cls;
            int          lat;
            sel = $urandom_range(0, 19);
            cls = (sel < 6) ? 2'b00 : (sel < 12) ? 2'b01 : (sel < 19) ? 2'b10 : 2'b11;
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
            run_instr(cls, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
